fir_core_sched: RTL

Time-multiplexes the single FIR core between NCH requester channels. Also owns the core's coefficient-load port.
- Arbitrates pending channel requests round-robin.
- Pulses the core's start with the granted sample.
- Captures the 41-bit result on the core's valid rising edge and returns it with the channel tag through a valid/ready handshake.
- Serialises coefficient writes, which are only accepted while the core is idle.

---
 rtl/fir_sched_pkg.sv | 16 +
 rtl/fir_core_sched_arb.sv | 33 +++
 rtl/fir_core_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR core scheduler.
// Holds the FSM state encoding, coefficient address width and the default job timeout.
package fir_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } sched_state_t;

    localparam int CADDR_W         = 6;
    localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/fir_core_sched_arb.sv
// Request arbiter: round-robin starting after 'last'; fixed lowest-index priority under FIR_SCHED_FIXED_PRIO_EN.
// Purely combinational, zero latency; no backpressure (gnt is all-zero when req is all-zero).
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] idx
);

    always_comb begin
        int  k;
        logic found;
        k     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < NCH; i++) begin
`ifdef FIR_SCHED_FIXED_PRIO_EN
            k = i;
`else
            k = (int'(last) + 1 + i) % NCH;
`endif
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k[$clog2(NCH)-1:0];
            end
        end
    end

endmodule

// File: rtl/fir_core_sched.sv
// Shares one FIR core between NCH channels and serialises coefficient writes; FIR_SCHED_FIXED_PRIO_EN selects fixed priority.
// Latency: request in IDLE -> grant/core_start next cycle; core_valid_out rise -> res_valid next cycle.
// Backpressure: result held in HOLD until res_ready; cfg_wr ignored while cfg_busy, requests wait in IDLE.
module fir_core_sched
    import fir_sched_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int RW      = 41,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*DW-1:0]      ch_din,
    output logic [NCH-1:0]         ch_gnt,
    input  logic                   cfg_wr,
    input  logic [CADDR_W-1:0]     cfg_addr,
    input  logic [DW-1:0]          cfg_data,
    output logic                   cfg_busy,
    output logic                   core_start,
    output logic                   core_valid_in,
    output logic [DW-1:0]          core_din,
    output logic                   core_cload,
    output logic [CADDR_W-1:0]     core_caddr,
    output logic [DW-1:0]          core_cin,
    input  logic [RW-1:0]          core_dout,
    input  logic                   core_valid_out,
    output logic                   res_valid,
    output logic [$clog2(NCH)-1:0] res_ch,
    output logic [RW-1:0]          res_data,
    input  logic                   res_ready,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(TIMEOUT);

    sched_state_t       state, state_nxt;
    logic [IW-1:0]      last;
    logic               vo_d;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      sample;
    logic [NCH-1:0]     gnt_r;
    logic [CADDR_W-1:0] caddr_r;
    logic [DW-1:0]      cdata_r;

    logic [NCH-1:0]     arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               vo_rise;
    logic               timeout_hit;
    logic               cfg_take;
    logic               job_take;
    logic               timeout_set;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req  (ch_req),
        .last (last),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign vo_rise     = core_valid_out && !vo_d;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign cfg_busy    = !((state == IDLE) && !core_valid_out);
    assign cfg_take    = (state == IDLE) && cfg_wr && !core_valid_out;
    // A job may only launch once the previous result's valid level has dropped.
    assign job_take    = (state == IDLE) && !cfg_take && (|ch_req) && !core_valid_out;
    assign timeout_set = (state == WAIT) && !vo_rise && timeout_hit;

    assign core_din    = sample;
    assign core_caddr  = caddr_r;
    assign core_cin    = cdata_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        core_start    = 1'b0;
        core_valid_in = 1'b0;
        core_cload    = 1'b0;
        ch_gnt        = '0;
        unique case (state)
            IDLE: begin
                if (cfg_take) begin
                    state_nxt = LOAD;
                end else if (job_take) begin
                    state_nxt = START;
                end
            end
            LOAD: begin
                core_cload = 1'b1;
                state_nxt  = IDLE;
            end
            START: begin
                core_start    = 1'b1;
                core_valid_in = 1'b1;
                ch_gnt        = gnt_r;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (vo_rise) begin
                    state_nxt = HOLD;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= IW'(NCH - 1);
            vo_d      <= 1'b0;
            cnt       <= '0;
            sample    <= '0;
            gnt_r     <= '0;
            caddr_r   <= '0;
            cdata_r   <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            vo_d <= core_valid_out;

            if (cfg_take) begin
                caddr_r <= cfg_addr;
                cdata_r <= cfg_data;
            end

            if (job_take) begin
                gnt_r  <= arb_gnt;
                res_ch <= arb_idx;
                sample <= ch_din[int'(arb_idx)*DW +: DW];
                last   <= arb_idx;
            end

            if (state == START) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end

            if ((state == WAIT) && vo_rise) begin
                res_data  <= core_dout;
                res_valid <= 1'b1;
            end else if ((state == HOLD) && res_ready) begin
                res_valid <= 1'b0;
            end

            // A timeout in the same cycle as err_clr leaves the flag set.
            if (timeout_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
